// File: rtl/ebab_arbiter.sv
// ebab_arbiter: round-robin sharing of one EBAB bridge port among NUM_REQ requesters
// Ports:
//   clk_clk, reset_reset                 clock, synchronous active-high reset
//   req_read / req_write                 per-requester level requests, held until req_acknowledge
//   req_address / req_byte_enable /
//   req_write_data                       packed per-requester operands, slice i = requester i
//   req_acknowledge / req_error          one-cycle completion / timeout pulse to the granted requester
//   req_read_data                        shared read data, valid in the ack cycle and held after
//   ebab_address/byte_enable/read/
//   write/write_data                     registered bridge drive
//   ebab_acknowledge / ebab_read_data    bridge completion and returned data
module ebab_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic [NUM_REQ-1:0]           req_read,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_address,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_byte_enable,
    input  logic [NUM_REQ*DATA_W-1:0]    req_write_data,
    output logic [NUM_REQ-1:0]           req_acknowledge,
    output logic [NUM_REQ-1:0]           req_error,
    output logic [DATA_W-1:0]            req_read_data,
    output logic [ADDR_W-1:0]            ebab_address,
    output logic [DATA_W/8-1:0]          ebab_byte_enable,
    output logic                         ebab_read,
    output logic                         ebab_write,
    output logic [DATA_W-1:0]            ebab_write_data,
    input  logic                         ebab_acknowledge,
    input  logic [DATA_W-1:0]            ebab_read_data
);
    localparam int BE_W = DATA_W / 8;
    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_q, rr_d, gnt_q, gnt_d, pick;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wd_q, wd_d, rdata_q, rdata_d;
    logic                rd_q, rd_d, wr_q, wr_d, found;
    logic [NUM_REQ-1:0]  ack_q, ack_d, err_q, err_d, req_any, gnt_oh;

    assign req_any = req_read | req_write;
    assign gnt_oh  = NUM_REQ'(1) << gnt_q;

    // Descending scan so the requester closest above the rr pointer is assigned last and wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_any[(int'(rr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d = ISSUE;
                gnt_d   = pick;
                cnt_d   = '0;
                addr_d  = req_address[pick*ADDR_W +: ADDR_W];
                be_d    = req_byte_enable[pick*BE_W +: BE_W];
                wd_d    = req_write_data[pick*DATA_W +: DATA_W];
                wr_d    = req_write[pick];
                rd_d    = ~req_write[pick];
            end
            ISSUE: if (ebab_acknowledge) begin
                state_d = DONE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                ack_d   = gnt_oh;
                rdata_d = rd_q ? ebab_read_data : rdata_q;
            end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                state_d = DONE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                ack_d   = gnt_oh;
                err_d   = gnt_oh;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign req_acknowledge  = ack_q;
    assign req_error        = err_q;
    assign req_read_data    = rdata_q;
    assign ebab_address     = addr_q;
    assign ebab_byte_enable = be_q;
    assign ebab_read        = rd_q;
    assign ebab_write       = wr_q;
    assign ebab_write_data  = wd_q;
endmodule

// File: tb/tb_ebab_arbiter.sv
// tb_ebab_arbiter: randomized check of ebab_arbiter against a transaction-level model
module tb_ebab_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [N-1:0]      req_read = '0, req_write = '0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N*BW-1:0]   req_byte_enable = '0;
    logic [N*DW-1:0]   req_write_data = '0;
    logic [N-1:0]      req_acknowledge, req_error;
    logic [DW-1:0]     req_read_data;
    logic [AW-1:0]     ebab_address;
    logic [BW-1:0]     ebab_byte_enable;
    logic              ebab_read, ebab_write;
    logic [DW-1:0]     ebab_write_data;
    logic              ebab_acknowledge = 1'b0;
    logic [DW-1:0]     ebab_read_data = '0;

    ebab_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_clk(clk), .reset_reset(reset_reset),
        .req_read(req_read), .req_write(req_write), .req_address(req_address),
        .req_byte_enable(req_byte_enable), .req_write_data(req_write_data),
        .req_acknowledge(req_acknowledge), .req_error(req_error), .req_read_data(req_read_data),
        .ebab_address(ebab_address), .ebab_byte_enable(ebab_byte_enable),
        .ebab_read(ebab_read), .ebab_write(ebab_write), .ebab_write_data(ebab_write_data),
        .ebab_acknowledge(ebab_acknowledge), .ebab_read_data(ebab_read_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rr = 0, op = 0, lat = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic [N-1:0]  act = '0, rd = '0, wr = '0;
    logic [AW-1:0] addr [N];
    logic [BW-1:0] be [N];
    logic [DW-1:0] wd [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_read[i]                  = act[i] & rd[i];
            req_write[i]                 = act[i] & wr[i];
            req_address[i*AW +: AW]      = addr[i];
            req_byte_enable[i*BW +: BW]  = be[i];
            req_write_data[i*DW +: DW]   = wd[i];
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        act[i] = 1'b1; rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
        drive();
    endtask

    // Round-robin rule: first active requester at or above rr, wrapping.
    function automatic int exp_grant();
        for (int k = 0; k < N; k++)
            if (act[(rr + k) % N]) return (rr + k) % N;
        return 0;
    endfunction

    task automatic do_reset();
        reset_reset = 1'b1;
        ebab_acknowledge = 1'b0;
        act = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_reset = 1'b0;
        rr = 0;
        exp_rdata = '0;
        check("rst_ctl", {req_acknowledge, req_error, ebab_read, ebab_write}, 0);
        check("rst_addr", ebab_address, 0);
        check("rst_be", ebab_byte_enable, 0);
        check("rst_wd", ebab_write_data, 0);
        check("rst_rdata", req_read_data, 0);
    endtask

    // Entered #1 into an IDLE cycle with at least one request driven; leaves #1 into the next IDLE.
    // lat < 0: bridge never acknowledges; otherwise ack in ISSUE cycle lat+1.
    task automatic run_txn(input int l, input logic [DW-1:0] rdat);
        int g, n;
        logic w;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [DW-1:0] d;
        g = exp_grant();
        w = wr[g]; a = addr[g]; b = be[g]; d = wd[g];
        n = (l < 0) ? TO : l + 1;
        check("idle_strobe", {ebab_read, ebab_write}, 0);
        @(posedge clk);
        #1;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            check("issue_rd", ebab_read, !w);
            check("issue_wr", ebab_write, w);
            check("issue_addr", ebab_address, a);
            check("issue_be", ebab_byte_enable, b);
            check("issue_wd", ebab_write_data, d);
            check("issue_ack", {req_acknowledge, req_error}, 0);
            addr[g] = AW'($urandom);
            wd[g] = DW'($urandom);
            drive();
            ebab_acknowledge = (l >= 0 && c == n);
            ebab_read_data = (c == n) ? rdat : DW'($urandom);
        end
        @(posedge clk);
        #1;
        ebab_acknowledge = 1'b0;
        if (l >= 0 && !w) exp_rdata = rdat;
        rr = (g + 1) % N;
        check("done_strobe", {ebab_read, ebab_write}, 0);
        check("done_ack", req_acknowledge, 1 << g);
        check("done_err", req_error, (l < 0) ? (1 << g) : 0);
        check("done_rdata", req_read_data, exp_rdata);
        act[g] = 1'b0;
        drive();
        ebab_acknowledge = 1'($urandom_range(0, 1));
        ebab_read_data = DW'($urandom);
        @(posedge clk);
        #1;
        ebab_acknowledge = 1'b0;
        check("idle_ack", {req_acknowledge, req_error}, 0);
        check("idle_rdata", req_read_data, exp_rdata);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; be[i] = '0; wd[i] = '0;
        end
        do_reset();
        set_req(0, 1'b1, 1'b0, 12'h123, 2'b11, 16'h0);
        run_txn(2, 16'hBEEF);
        check("t1_rdata", req_read_data, 16'hBEEF);

        do_reset();
        set_req(0, 1'b0, 1'b1, 12'h100, 2'b11, 16'hA000);
        set_req(1, 1'b0, 1'b1, 12'h200, 2'b10, 16'hB000);
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(0, 3);
            op = exp_grant();
            run_txn(lat, DW'($urandom));
            set_req(op, 1'b0, 1'b1, AW'($urandom), BW'($urandom), DW'($urandom));
        end
        act = '0;
        drive();

        set_req(1, 1'b0, 1'b1, 12'hFFF, 2'b01, 16'h55AA);
        run_txn(3, 16'h1234);

        set_req(0, 1'b1, 1'b0, 12'h0AA, 2'b00, 16'h0);
        set_req(1, 1'b0, 1'b1, 12'h0BB, 2'b11, 16'h7777);
        run_txn(-1, 16'hDEAD);
        run_txn(0, 16'h4321);

        set_req(0, 1'b1, 1'b1, 12'h321, 2'b11, 16'hCAFE);
        run_txn(1, 16'h9999);

        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(0, 1) == 1) begin
                    op = $urandom_range(0, 2);
                    set_req(i, op != 1, op != 0, AW'($urandom), BW'($urandom), DW'($urandom));
                end
            end
            if (act == '0) set_req($urandom_range(0, N - 1), 1'b1, 1'b0, AW'($urandom), BW'($urandom), 16'h0);
            lat = $urandom_range(0, 9);
            run_txn((lat > 5) ? -1 : lat, DW'($urandom));
        end

        act = '0;
        drive();
        set_req(1, 1'b0, 1'b1, 12'h0F0, 2'b11, 16'h5A5A);
        @(posedge clk);
        #1;
        check("rst_mid_issue", ebab_write, 1);
        reset_reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 12'h02A, 2'b11, 16'h0);
        @(posedge clk);
        #1;
        reset_reset = 1'b0;
        check("rst_mid_strobe", {ebab_read, ebab_write}, 0);
        check("rst_mid_ack", {req_acknowledge, req_error}, 0);
        check("rst_mid_addr", ebab_address, 0);
        ebab_acknowledge = 1'b1;
        ebab_read_data = 16'hFACE;
        rr = 0;
        exp_rdata = '0;
        run_txn(1, 16'h0C0C);
        run_txn(0, 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
